// File: rtl/dec_4x16_seq_if.sv
// Signal bundle for the registered 4-to-16 decoder: code/strobe inputs from
// the controlling side, one-hot strobe, busy, current code and done back.
interface dec_4x16_seq_if;
   logic s3, s2, s1, s0;
   logic en;
   logic scan_start;
   logic clr;
   logic y0, y1, y2, y3, y4, y5, y6, y7;
   logic y8, y9, y10, y11, y12, y13, y14, y15;
   logic busy;
   logic code3, code2, code1, code0;
   logic done;

   modport master (
      output s3, s2, s1, s0, en, scan_start, clr,
      input  y0, y1, y2, y3, y4, y5, y6, y7,
      input  y8, y9, y10, y11, y12, y13, y14, y15,
      input  busy, code3, code2, code1, code0, done
   );

   modport slave (
      input  s3, s2, s1, s0, en, scan_start, clr,
      output y0, y1, y2, y3, y4, y5, y6, y7,
      output y8, y9, y10, y11, y12, y13, y14, y15,
      output busy, code3, code2, code1, code0, done
   );
endinterface

// File: rtl/dec_4x16_seq.sv
// Registered 4-to-16 decoder with a programmable hold time and an optional
// 0..15 sweep sequencer for bring-up of the select/enable fabric.
// Build option: define DEC_SCAN_EN to compile in the SCAN state and the
// scan_start path; without it only the IDLE/HOLD behaviour exists.
// All outputs come straight from flops; next values are computed from the
// next state so the strobe appears on the cycle after the load edge.
module dec_4x16_seq #(
   parameter int HOLD = 1
) (
   input logic         clk,
   input logic         rst_n,
   dec_4x16_seq_if.slave bus
);

   // A hold of 0 behaves as 1; the counter is 8 bits so cap at 255.
   localparam int         HOLD_EFF = (HOLD < 1) ? 1 : ((HOLD > 255) ? 255 : HOLD);
   localparam logic [7:0] RELOAD   = 8'(HOLD_EFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1
`ifdef DEC_SCAN_EN
      ,
      ST_SCAN = 2'd2
`endif
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  code_reg, code_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [15:0] y_reg, y_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic [3:0]  s_code;

   assign s_code = {bus.s3, bus.s2, bus.s1, bus.s0};

`ifndef DEC_SCAN_EN
   // scan_start has no function in this build.
   logic unused_scan_start;
   assign unused_scan_start = bus.scan_start;
`endif

   // Next-state, code/counter sequencing and registered-output precompute.
   always_comb begin
      state_next = state_reg;
      code_next  = code_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      y_next     = '0;
      busy_next  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
`ifdef DEC_SCAN_EN
            if (bus.scan_start) begin
               state_next = ST_SCAN;
               code_next  = 4'd0;
               cnt_next   = RELOAD;
            end else
`endif
            if (bus.en) begin
               state_next = ST_HOLD;
               code_next  = s_code;
               cnt_next   = RELOAD;
            end
         end
         ST_HOLD: begin
            if (bus.clr) begin
               state_next = ST_IDLE;
               cnt_next   = 8'd0;
            end else if (cnt_reg == 8'd0) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
`ifdef DEC_SCAN_EN
         ST_SCAN: begin
            if (bus.clr) begin
               state_next = ST_IDLE;
               cnt_next   = 8'd0;
            end else if (cnt_reg == 8'd0) begin
               // The sweep ends on code 15; it never wraps back to 0.
               if (code_reg == 4'd15) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end else begin
                  code_next = code_reg + 4'd1;
                  cnt_next  = RELOAD;
               end
            end else begin
               cnt_next = cnt_reg - 8'd1;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (state_next != ST_IDLE) begin
         y_next[code_next] = 1'b1;
         busy_next         = 1'b1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         code_reg  <= 4'd0;
         cnt_reg   <= 8'd0;
         y_reg     <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         code_reg  <= code_next;
         cnt_reg   <= cnt_next;
         y_reg     <= y_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign bus.y0    = y_reg[0];
   assign bus.y1    = y_reg[1];
   assign bus.y2    = y_reg[2];
   assign bus.y3    = y_reg[3];
   assign bus.y4    = y_reg[4];
   assign bus.y5    = y_reg[5];
   assign bus.y6    = y_reg[6];
   assign bus.y7    = y_reg[7];
   assign bus.y8    = y_reg[8];
   assign bus.y9    = y_reg[9];
   assign bus.y10   = y_reg[10];
   assign bus.y11   = y_reg[11];
   assign bus.y12   = y_reg[12];
   assign bus.y13   = y_reg[13];
   assign bus.y14   = y_reg[14];
   assign bus.y15   = y_reg[15];
   assign bus.busy  = busy_reg;
   assign bus.done  = done_reg;
   assign bus.code3 = code_reg[3];
   assign bus.code2 = code_reg[2];
   assign bus.code1 = code_reg[1];
   assign bus.code0 = code_reg[0];

endmodule

// File: tb/tb_dec_4x16_seq.sv
// Directed bench for dec_4x16_seq. Five instances (HOLD = 1, 2, 3, 4 and 0)
// share the clock and reset; sel routes the stimulus to one of them and picks
// which one is observed. Expected per-cycle outputs are queued as stimulus is
// driven and popped one per clock edge.
module tb_dec_4x16_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, scan_start, clr;
   logic [3:0] s;
   int         sel;

   always #5 clk = ~clk;

   logic [15:0] y_all    [5];
   logic        busy_all [5];
   logic        done_all [5];
   logic [3:0]  code_all [5];

   for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      dec_4x16_seq_if bus ();
      assign bus.s3         = s[3];
      assign bus.s2         = s[2];
      assign bus.s1         = s[1];
      assign bus.s0         = s[0];
      assign bus.en         = (sel == gi) ? en : 1'b0;
      assign bus.scan_start = (sel == gi) ? scan_start : 1'b0;
      assign bus.clr        = (sel == gi) ? clr : 1'b0;
      assign y_all[gi] = {bus.y15, bus.y14, bus.y13, bus.y12, bus.y11, bus.y10, bus.y9, bus.y8,
                          bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
      assign busy_all[gi] = bus.busy;
      assign done_all[gi] = bus.done;
      assign code_all[gi] = {bus.code3, bus.code2, bus.code1, bus.code0};

      dec_4x16_seq #(.HOLD((gi == 4) ? 0 : gi + 1)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   typedef struct packed {
      logic [15:0] y;
      logic        busy;
      logic        done;
      logic [3:0]  code;
      logic        chk_code;
   } exp_t;

   exp_t       sb [$];
   int         errors = 0;
   int         checks = 0;
   logic [3:0] mcode  [5];
   bit         mknown [5];

   task automatic push(input logic [15:0] y, input logic busy, input logic done);
      exp_t e;
      e.y        = y;
      e.busy     = busy;
      e.done     = done;
      e.code     = mcode[sel];
      e.chk_code = mknown[sel];
      sb.push_back(e);
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s no expected entry: queue size observed=%0d required>0", tag, sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (y_all[sel] === e.y) else begin
            errors++;
            $error("FAIL %s y observed=%h expected=%h", tag, y_all[sel], e.y);
         end
         checks++;
         assert (busy_all[sel] === e.busy) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy_all[sel], e.busy);
         end
         checks++;
         assert (done_all[sel] === e.done) else begin
            errors++;
            $error("FAIL %s done observed=%b expected=%b", tag, done_all[sel], e.done);
         end
         if (e.chk_code) begin
            checks++;
            assert (code_all[sel] === e.code) else begin
               errors++;
               $error("FAIL %s code observed=%0d expected=%0d", tag, code_all[sel], e.code);
            end
         end
         $display("tick %-12s sel=%0d y=%h busy=%b done=%b code=%0d", tag, sel,
                  y_all[sel], busy_all[sel], done_all[sel], code_all[sel]);
      end
   endtask

   task automatic idle(input int n, input string tag);
      repeat (n) begin
         push(16'h0, 1'b0, 1'b0);
         tick(tag);
      end
   endtask

   // One load with code c and effective hold h: h strobe cycles then done.
   task automatic load(input logic [3:0] c, input int h, input string tag);
      s           = c;
      en          = 1'b1;
      mcode[sel]  = c;
      mknown[sel] = 1'b1;
      repeat (h) push(16'h1 << c, 1'b1, 1'b0);
      push(16'h0, 1'b0, 1'b1);
      tick(tag);
      en = 1'b0;
      repeat (h) tick(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; scan_start = 1'b0; clr = 1'b0; s = 4'd0; sel = 3;
      for (int i = 0; i < 5; i++) begin
         mcode[i]  = 4'd0;
         mknown[i] = 1'b1;
      end

      // Reset state
      idle(2, "reset");
      rst_n = 1'b1;
      idle(1, "post_reset");

      // Reset in the middle of a HOLD=4 hold of code 9
      s = 4'd9; en = 1'b1; mcode[3] = 4'd9;
      repeat (2) push(16'h1 << 9, 1'b1, 1'b0);
      tick("rst_hold");
      en = 1'b0;
      tick("rst_hold");
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) mcode[i] = 4'd0;
      push(16'h0, 1'b0, 1'b0);
      tick("rst_mid");
      rst_n = 1'b1;
      idle(1, "rst_release");
      load(4'd3, 4, "rst_reload");
      idle(1, "rst_reload");

      // HOLD=1: every code on alternate cycles, en accepted in the done cycle
      sel = 0;
      for (int k = 0; k < 16; k++) load(4'(k), 1, "stim_sweep");
      idle(1, "stim_sweep");

      // HOLD=3: code 12, en with code 5 mid-hold is ignored
      sel = 2;
      s = 4'd12; en = 1'b1; mcode[2] = 4'd12;
      repeat (3) push(16'h1 << 12, 1'b1, 1'b0);
      push(16'h0, 1'b0, 1'b1);
      tick("hold3");
      en = 1'b0;
      tick("hold3");
      s = 4'd5; en = 1'b1;
      tick("ignore_en");
      en = 1'b0;
      tick("hold3_done");
      idle(1, "ignore_en");
      load(4'd1, 3, "b2b");
      load(4'd2, 3, "b2b");
      idle(1, "b2b");

      // HOLD=0 behaves as HOLD=1
      sel = 4;
      load(4'd6, 1, "hold0");
      idle(1, "hold0");

      // Abort during a HOLD=4 hold
      sel = 3;
      s = 4'd7; en = 1'b1; mcode[3] = 4'd7;
      repeat (2) push(16'h1 << 7, 1'b1, 1'b0);
      tick("abort_hold");
      en = 1'b0;
      tick("abort_hold");
      clr = 1'b1; mknown[3] = 1'b0;
      push(16'h0, 1'b0, 1'b0);
      tick("abort_hold");
      clr = 1'b0;
      idle(2, "abort_nodone");
      load(4'd15, 4, "after_abort");
      idle(1, "after_abort");

`ifdef DEC_SCAN_EN
      // HOLD=2 sweep started together with en: scan wins
      sel = 1;
      scan_start = 1'b1; en = 1'b1; s = 4'd7;
      for (int k = 0; k < 16; k++) begin
         mcode[1] = 4'(k);
         repeat (2) push(16'h1 << k, 1'b1, 1'b0);
      end
      push(16'h0, 1'b0, 1'b1);
      tick("scan");
      scan_start = 1'b0; en = 1'b0;
      repeat (32) tick("scan");
      idle(2, "scan_end");

      // HOLD=1 sweep aborted while y7 is high
      sel = 0;
      scan_start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         mcode[0] = 4'(k);
         push(16'h1 << k, 1'b1, 1'b0);
      end
      tick("scan_abort");
      scan_start = 1'b0;
      repeat (7) tick("scan_abort");
      clr = 1'b1; mknown[0] = 1'b0;
      push(16'h0, 1'b0, 1'b0);
      tick("scan_abort");
      clr = 1'b0;
      idle(2, "scan_nodone");
      load(4'd15, 1, "scan_after");
      idle(1, "scan_after");
`else
      // No sweep in this build: scan_start alone does nothing
      sel = 0;
      scan_start = 1'b1;
      push(16'h0, 1'b0, 1'b0);
      tick("noscan");
      scan_start = 1'b0;
      idle(2, "noscan");
      // scan_start together with en: the ordinary load happens
      scan_start = 1'b1;
      load(4'd7, 1, "noscan_en");
      scan_start = 1'b0;
      idle(1, "noscan_en");
`endif

      // clr in IDLE has no effect
      sel = 0;
      clr = 1'b1;
      idle(2, "clr_idle");
      clr = 1'b0;
      load(4'd10, 1, "clr_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dec_4x16_seq.md
# dec_4x16_seq

Registered 4-to-16 decoder with a timed hold and an automatic sweep sequencer. It is the inverse of the 16-to-4 select encoder in the 19-bit CPU. It turns a 4-bit code on s3..s0 into a one-hot strobe on y0..y15, held for a programmable number of cycles. A scan mode walks all 16 codes in order for bring-up of the register-select and bus-enable fabric.

## Interface
Parameters:
- HOLD, default 1: cycles each one-hot code is held. Legal range 1..255; 0 is treated as 1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- s3, s2, s1, s0  input  1 each  code to decode; s3 is MSB
- en  input  1  load strobe; sampled only in IDLE
- scan_start  input  1  start 0..15 sweep; sampled only in IDLE
- clr  input  1  synchronous abort to IDLE; ignored while rst_n is low
- y0 .. y15  output  1 each  one-hot decoded strobe; all 0 when not holding
- busy  output  1  high in HOLD or SCAN
- code3 .. code0  output  1 each  registered code currently driven
- done  output  1  one-cycle pulse at end of a hold or a sweep

## Operation
- Reset: rst_n low at an edge forces the following, regardless of state. State becomes IDLE. y0..y15=0, busy=0, done=0, code=0, hold counter=0.
- IDLE
  - scan_start=1: load code=0 and counter=HOLD-1, then go to SCAN.
  - Otherwise en=1: latch {s3,s2,s1,s0} into code, load counter=HOLD-1, then go to HOLD.
  - scan_start has priority when both are high.
- HOLD
  - Drive y[code]=1, busy=1.
  - Counter decrements each cycle. When the counter is 0, go to IDLE and pulse done.
  - en, scan_start and s3..s0 are ignored.
- SCAN
  - Drive y[code]=1, busy=1.
  - When the counter is 0 and code<15: code increments and the counter reloads HOLD-1.
  - When the counter is 0 and code==15: go to IDLE and pulse done.
  - code never wraps to 0 inside a sweep.
- clr=1 in HOLD or SCAN: go to IDLE next edge with y=0, busy=0, done=0. No done pulse. clr in IDLE has no effect.
- Outputs are fully registered. Exactly zero or one y bit is high at any time.
- done is asserted the cycle after the last held cycle, coincident with IDLE. In that cycle y=0 and busy=0. A new en sampled in that cycle is accepted.

## Timing
- Single load: en and a code are sampled at edge T.
  - y[code] and busy are high for cycles T+1 .. T+HOLD.
  - done is high at T+HOLD+1.
  - Earliest next accept is edge T+HOLD+1.
- Sweep: scan_start is sampled at edge T.
  - Code k is driven during cycles T+1+k·HOLD .. T+(k+1)·HOLD.
  - done is high at T+16·HOLD+1.
- HOLD=1: single load gives a one-cycle strobe, and the sweep takes 16 consecutive cycles.
- Counter width is 8 bits. Code width is 4 bits.

## Configuration
- DEC_SCAN_EN
  - Defined: SCAN state, scan_start logic and sweep sequencing are compiled in.
  - Undefined: scan_start is ignored and no SCAN state exists. Only IDLE/HOLD behaviour remains; timing is unchanged.

## Test plan
- Reset: drive rst_n=0 mid-HOLD with HOLD=4 and code=9 -> next edge y=0, busy=0, done=0, code=0. After release, en with code 3 -> y3 high for 4 cycles.
- Single decode sweep by stimulus: HOLD=1, apply en with each code 0..15 on alternate cycles -> y[k] high exactly one cycle per load, other bits 0, done one cycle after each.
- Hold length: HOLD=3, en with code=12 at edge T -> y12 high T+1..T+3, done at T+4. An en at T+2 with code=5 is ignored.
- Scan (DEC_SCAN_EN): HOLD=2, scan_start -> y0..y15 each high 2 cycles in order, done at T+33, busy low at T+33. With en and scan_start together -> scan runs.
- Abort: HOLD=1, clr asserted while y7 is high during a scan -> next cycle IDLE, y=0, no done. A following en with code=15 -> y15 high one cycle.
- Build without DEC_SCAN_EN: scan_start pulse -> busy stays 0 and y stays 0. en path is unchanged.
